// File: rtl/seq_pkg.sv
// Shared state encoding, widths, ROM entry type and fixed 16-step pattern ROM
// for the voice note sequencer.
package seq_pkg;

    localparam int unsigned ENTRY_W   = 5;
    localparam int unsigned NOTE_W    = 4;
    localparam int unsigned ROM_IDX_W = 4;
    localparam int unsigned TEMPO_W   = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GATE_ON  = 2'd1,
        GATE_OFF = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic              rest;
        logic [NOTE_W-1:0] note;
    } seq_entry_t;

    // Pattern: 0,2,4,5,7,5,4,2,R,4,7,11,R,9,7,4 (R = rest, 5'h10)
    function automatic seq_entry_t seq_rom(input logic [ROM_IDX_W-1:0] idx);
        logic [ENTRY_W-1:0] e;
        case (idx)
            4'd0:    e = 5'h00;
            4'd1:    e = 5'h02;
            4'd2:    e = 5'h04;
            4'd3:    e = 5'h05;
            4'd4:    e = 5'h07;
            4'd5:    e = 5'h05;
            4'd6:    e = 5'h04;
            4'd7:    e = 5'h02;
            4'd8:    e = 5'h10;
            4'd9:    e = 5'h04;
            4'd10:   e = 5'h07;
            4'd11:   e = 5'h0b;
            4'd12:   e = 5'h10;
            4'd13:   e = 5'h09;
            4'd14:   e = 5'h07;
            default: e = 5'h04;
        endcase
        return seq_entry_t'(e);
    endfunction

endpackage

// File: rtl/seq_step_timer.sv
// Per-step cycle counter: latches the step length at load and flags the last
// gate-high cycle and the last step cycle. Swing timing under VOICE_SEQ_SWING_EN.
module seq_step_timer
    import seq_pkg::*;
#(
    parameter int unsigned TICK_SHIFT = 10,
    parameter int unsigned GATE_SHIFT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               active,
    input  logic               odd_step,
    input  logic [TEMPO_W-1:0] len_code,
    output logic               gate_end,
    output logic               step_end
);

    localparam int unsigned CNT_W = TEMPO_W + 1 + TICK_SHIFT;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] gate_len_q;
    logic [CNT_W-1:0] len_c;
    logic [CNT_W-1:0] gate_len_c;

    // Length of the step about to start, and its gate-high length (never 0)
    always_comb begin
        len_c = CNT_W'({1'b0, len_code} + 9'd1) << TICK_SHIFT;
`ifdef VOICE_SEQ_SWING_EN
        if (odd_step) begin
            len_c = len_c + (len_c >> 2);
        end else begin
            len_c = len_c - (len_c >> 2);
        end
`endif
        gate_len_c = len_c >> GATE_SHIFT;
        if (gate_len_c == '0) begin
            gate_len_c = CNT_W'(1);
        end
    end

`ifndef VOICE_SEQ_SWING_EN
    logic unused_odd_step;
    assign unused_odd_step = odd_step;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            len_q      <= '0;
            gate_len_q <= '0;
        end else if (load) begin
            cnt_q      <= '0;
            len_q      <= len_c;
            gate_len_q <= gate_len_c;
        end else if (!active || step_end) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign step_end = active && (cnt_q == len_q - CNT_W'(1));
    assign gate_end = active && (cnt_q == gate_len_q - CNT_W'(1));

endmodule

// File: rtl/voice_note_sequencer.sv
// Step sequencer for the synth voice: plays the seq_pkg pattern ROM at a
// programmable tempo with manual-note preemption. Optional swing: VOICE_SEQ_SWING_EN.
module voice_note_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned STEPS      = 16,
    parameter int unsigned TICK_SHIFT = 10,
    parameter int unsigned GATE_SHIFT = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     run,
    input  logic [TEMPO_W-1:0]       tempo,
    input  logic                     manual_req,
    input  logic [NOTE_W-1:0]        manual_note,
    output logic                     manual_ack,
    output logic [NOTE_W-1:0]        note_out,
    output logic                     gate,
    output logic [$clog2(STEPS)-1:0] step_idx,
    output logic                     step_strobe
);

    localparam int unsigned IDX_W = $clog2(STEPS);

    seq_state_e        state_q, state_d;
    logic [NOTE_W-1:0] note_q, note_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              gate_q, gate_d;
    logic              strobe_q, strobe_d;
    logic              ack_q, ack_d;
    logic              load;
    logic              gate_end;
    logic              step_end;
    seq_entry_t        entry;

    seq_step_timer #(
        .TICK_SHIFT (TICK_SHIFT),
        .GATE_SHIFT (GATE_SHIFT)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .active   (state_q != IDLE),
        .odd_step (idx_d[0]),
        .len_code (tempo),
        .gate_end (gate_end),
        .step_end (step_end)
    );

    // Next-state and registered-output logic; a load starts a new step
    always_comb begin
        state_d  = state_q;
        note_d   = note_q;
        idx_d    = idx_q;
        gate_d   = gate_q;
        strobe_d = 1'b0;
        ack_d    = 1'b0;
        load     = 1'b0;
        entry    = '0;

        case (state_q)
            IDLE: begin
                if (run) begin
                    load  = 1'b1;
                    idx_d = '0;
                end
            end
            GATE_ON, GATE_OFF: begin
                if (step_end) begin
                    if (run) begin
                        load  = 1'b1;
                        idx_d = idx_q + IDX_W'(1);
                    end else begin
                        state_d = IDLE;
                        idx_d   = '0;
                        gate_d  = 1'b0;
                    end
                end else if (state_q == GATE_ON && gate_end) begin
                    state_d = GATE_OFF;
                    gate_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                gate_d  = 1'b0;
            end
        endcase

        if (load) begin
            strobe_d = 1'b1;
            entry    = seq_rom(ROM_IDX_W'(idx_d));
            if (manual_req) begin
                note_d  = manual_note;
                ack_d   = 1'b1;
                state_d = GATE_ON;
                gate_d  = 1'b1;
            end else begin
                note_d  = entry.note;
                state_d = entry.rest ? GATE_OFF : GATE_ON;
                gate_d  = !entry.rest;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            note_q   <= '0;
            idx_q    <= '0;
            gate_q   <= 1'b0;
            strobe_q <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            note_q   <= note_d;
            idx_q    <= idx_d;
            gate_q   <= gate_d;
            strobe_q <= strobe_d;
            ack_q    <= ack_d;
        end
    end

    assign manual_ack  = ack_q;
    assign note_out    = note_q;
    assign gate        = gate_q;
    assign step_idx    = idx_q;
    assign step_strobe = strobe_q;

endmodule
